// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: FSM states, round constants and block type.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } ks_state_e;

  localparam logic [7:0] RCON [NUM_ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
  };

  // Counter values past the last round select zero rather than reading off the table.
  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < NUM_ROUNDS; i++) begin
      if (idx == 4'(i)) r = RCON[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/key_schedule_if.sv
// Request/status/round-key bundle between a key-schedule client and the expander.
interface key_schedule_if;
  import aes_pkg::*;

  logic   start;
  block_t keyword;
  logic   busy;
  logic   done;
  block_t subkey0, subkey1, subkey2, subkey3, subkey4;
  block_t subkey5, subkey6, subkey7, subkey8, subkey9;

  modport master (
    output start, keyword,
    input  busy, done,
    input  subkey0, subkey1, subkey2, subkey3, subkey4,
    input  subkey5, subkey6, subkey7, subkey8, subkey9
  );

  modport slave (
    input  start, keyword,
    output busy, done,
    output subkey0, subkey1, subkey2, subkey3, subkey4,
    output subkey5, subkey6, subkey7, subkey8, subkey9
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y_o = SBOX[a_i];

endmodule

// File: rtl/key_schedule.sv
// Iterative AES-128 key expansion: one round key per clock, ten round keys held on the outputs.
module key_schedule
  import aes_pkg::*;
(
  input  logic          HCLK,
  input  logic          n_rst,
  key_schedule_if.slave ks
);

  ks_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  block_t     wkey_q, wkey_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       rk_we;
  block_t     rk_q [NUM_ROUNDS];

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w, temp_w;
  logic [31:0] n0, n1, n2, n3;
  block_t      next_key;

  assign {w0, w1, w2, w3} = wkey_q;
  assign rot_w = {w3[23:0], w3[31:24]};

  genvar b;
  generate
    for (b = 0; b < 4; b++) begin : g_subword
      aes_sbox u_sbox (
        .a_i (rot_w[8*b +: 8]),
        .y_o (sub_w[8*b +: 8])
      );
    end
  endgenerate

  assign temp_w   = sub_w ^ {rcon_of(cnt_q), 24'h000000};
  assign n0       = w0 ^ temp_w;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wkey_d  = wkey_q;
    busy_d  = busy_q;
    done_d  = done_q;
    rk_we   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (ks.start) begin
          wkey_d  = ks.keyword;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        // start is deliberately not looked at here: a running expansion cannot be restarted.
        wkey_d = next_key;
        rk_we  = 1'b1;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'(NUM_ROUNDS - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wkey_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wkey_q  <= wkey_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Round keys are cleared on reset so an aborted expansion leaves nothing behind.
  always_ff @(posedge HCLK or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_ROUNDS; i++) rk_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ROUNDS; i++) begin
        if (rk_we && (cnt_q == 4'(i))) rk_q[i] <= next_key;
      end
    end
  end

  assign ks.busy    = busy_q;
  assign ks.done    = done_q;
  assign ks.subkey0 = rk_q[0];
  assign ks.subkey1 = rk_q[1];
  assign ks.subkey2 = rk_q[2];
  assign ks.subkey3 = rk_q[3];
  assign ks.subkey4 = rk_q[4];
  assign ks.subkey5 = rk_q[5];
  assign ks.subkey6 = rk_q[6];
  assign ks.subkey7 = rk_q[7];
  assign ks.subkey8 = rk_q[8];
  assign ks.subkey9 = rk_q[9];

endmodule

// File: tb/tb_key_schedule.sv
// Scoreboarded bench for key_schedule against a GF(2^8)-arithmetic AES-128 key expansion model.
module tb_key_schedule;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;

  key_schedule_if ks ();

  key_schedule dut (
    .HCLK  (clk),
    .n_rst (n_rst),
    .ks    (ks)
  );

  typedef struct packed {
    logic [1279:0] keys;
    logic [31:0]   cyc;
  } exp_t;

  exp_t         exp_q [$];
  int           checks = 0;
  int           errors = 0;
  logic [31:0]  cyc = 0;
  logic [7:0]   sbox_ref [256];
  logic         done_prev = 1'b0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;

  wire [127:0] got [10];
  assign got[0] = ks.subkey0;
  assign got[1] = ks.subkey1;
  assign got[2] = ks.subkey2;
  assign got[3] = ks.subkey3;
  assign got[4] = ks.subkey4;
  assign got[5] = ks.subkey5;
  assign got[6] = ks.subkey6;
  assign got[7] = ks.subkey7;
  assign got[8] = ks.subkey8;
  assign got[9] = ks.subkey9;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from first principles: multiplicative inverse (a^254) then the affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = (a == 8'h00) ? 8'h00 : 8'h01;
    if (a != 8'h00) begin
      for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  // Word-array key expansion (w[0..43]); round key k is w[4k..4k+3], subkeyN is round key N+1.
  function automatic logic [1279:0] model_expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1279:0] r;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 10; k++) r[k*128 +: 128] = {w[4*k+4], w[4*k+5], w[4*k+6], w[4*k+7]};
    return r;
  endfunction

  // Monitor: every rising edge of done retires one expected expansion.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (n_rst) begin
      chk1("busy_done_exclusive", ks.busy & ks.done, 1'b0);
      if (ks.done && !done_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done actual=done_rose required=no_pending_expansion");
        end else begin
          e = exp_q.pop_front();
          chk("done_latency", 128'(cyc - e.cyc), 128'd10);
          for (int i = 0; i < 10; i++)
            chk($sformatf("subkey%0d", i), got[i], e.keys[i*128 +: 128]);
        end
      end
    end
    done_prev = ks.done;
  end

  task automatic run_key(input logic [127:0] key, input bit restart);
    exp_t e;
    @(posedge clk); #1;
    ks.start   = 1'b1;
    ks.keyword = key;
    @(posedge clk); #1;
    ks.start = 1'b0;
    e.keys = model_expand(key);
    e.cyc  = cyc;
    exp_q.push_back(e);
    chk1("accept_busy", ks.busy, 1'b1);
    chk1("accept_done_low", ks.done, 1'b0);
    for (int i = 1; i <= 11; i++) begin
      ks.keyword = {$urandom, $urandom, $urandom, $urandom};
      ks.start   = restart && (i == 4);
      @(posedge clk); #1;
    end
    ks.start = 1'b0;
  endtask

  task automatic reset_mid(input logic [127:0] key);
    @(posedge clk); #1;
    ks.start   = 1'b1;
    ks.keyword = key;
    @(posedge clk); #1;
    ks.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk1("pre_reset_busy", ks.busy, 1'b1);
    n_rst = 1'b0;
    #1;
    chk1("abort_busy", ks.busy, 1'b0);
    chk1("abort_done", ks.done, 1'b0);
    for (int i = 0; i < 10; i++) chk($sformatf("abort_subkey%0d", i), got[i], 128'h0);
    @(posedge clk); @(posedge clk); #1;
    n_rst = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
      chk1("idle_busy", ks.busy, 1'b0);
      chk1("idle_done", ks.done, 1'b0);
    end
    chk("idle_subkey0", got[0], 128'h0);
    chk("idle_subkey9", got[9], 128'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    ks.start   = 1'b0;
    ks.keyword = '0;
    for (int i = 0; i < 256; i++) sbox_ref[i] = sbox_calc(8'(i));

    #2 n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("reset_busy", ks.busy, 1'b0);
    chk1("reset_done", ks.done, 1'b0);
    for (int i = 0; i < 10; i++) chk($sformatf("reset_subkey%0d", i), got[i], 128'h0);
    n_rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk1("post_reset_idle_busy", ks.busy, 1'b0);
    chk1("post_reset_idle_done", ks.done, 1'b0);

    run_key(FIPS_KEY, 1'b0);
    chk("fips_subkey0", got[0], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_subkey1", got[1], 128'hf2c295f27a96b9435935807a7359f67f);
    chk("fips_subkey9", got[9], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_key(ZERO_KEY, 1'b0);
    chk("zero_subkey0", got[0], 128'h62636363626363636263636362636363);
    chk("zero_subkey9", got[9], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    chk1("zero_done_level", ks.done, 1'b1);

    run_key(FIPS_KEY, 1'b0);
    chk("b2b_fips_subkey0", got[0], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("b2b_fips_subkey9", got[9], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_key(FIPS_KEY, 1'b1);
    chk("restart_ignored_subkey9", got[9], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    for (int n = 0; n < 8; n++) run_key({$urandom, $urandom, $urandom, $urandom}, n[0]);

    reset_mid(FIPS_KEY);

    run_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    run_key(FIPS_KEY, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("pending_expansions", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 Parameters: none; round count fixed at 10 (AES-128).
REQ-002 HCLK  input  1  system clock, all state updates on rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request expansion of keyword; sampled on HCLK rising edge.
REQ-005 keyword  input  128  cipher key (round-0 key); bits [127:96] = word w0.
REQ-006 busy  output  1  expansion in progress.
REQ-007 done  output  1  all round keys valid; level, not pulse.
REQ-008 subkey0..subkey9  output  128 each  round keys 1..10; subkeyN = round key N+1.

Function
REQ-009 States: IDLE, EXPAND, DONE; state, 4-bit round counter, 128-bit working key, all registered.
REQ-010 IDLE or DONE with start=1 at edge E0: latch keyword into working key, counter<=0, done<=0, busy<=1, enter EXPAND.
REQ-011 EXPAND, each edge: compute one round key from working key and Rcon[counter], write it to subkey[counter] and working key, counter+1.
REQ-012 Round key: temp = SubWord(RotWord(w3)) ^ {Rcon,24'h0}; n0=w0^temp; n1=w1^n0; n2=w2^n1; n3=w3^n2; result {n0,n1,n2,n3}.
REQ-013 RotWord: {b1,b2,b3,b0}; SubWord: AES S-box on each byte, combinational.
REQ-014 Rcon sequence for counter 0..9: 01,02,04,08,10,20,40,80,1B,36.
REQ-015 Latency: subkey0 written at E1, subkey9 at E10; at E10 busy<=0, done<=1, state DONE.
REQ-016 start while in EXPAND: ignored; expansion continues unaffected.
REQ-017 keyword changes after E0: no effect on running or completed expansion.
REQ-018 subkey outputs hold last written value; a new expansion overwrites them in order (subkey0 first); done low throughout.
REQ-019 busy and done never both high; done stays high until next accepted start or reset.
REQ-020 start in DONE: restarts exactly as from IDLE (REQ-010).

Reset
REQ-021 n_rst low: immediately state IDLE, counter 0, working key 0, busy 0, done 0, subkey0..subkey9 all 0.
REQ-022 Reset mid-expansion: abort, all outputs as REQ-021; no partial keys retained.
REQ-023 After n_rst release, block idles until start; no spontaneous expansion.

Structure
REQ-024 Shared package aes_pkg: state enum, Rcon constant table, NUM_ROUNDS=10, 128-bit block typedef.
REQ-025 One sub-module aes_sbox (8-bit in, 8-bit out, combinational forward S-box); four instances for SubWord.
REQ-026 Round keys held in a 10-entry register array internally, mapped to the ten output ports.

Verification
REQ-027 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle -> subkey0=a0fafe1788542cb123a339392a6c7605, done high exactly 10 cycles after start edge.
REQ-028 Same run -> subkey9=d014f9a8c9ee2589e13f0cc8b6630ca6; subkey1=f2c295f27a96b9435935807a7359f67f.
REQ-029 Key all-zero -> subkey0=62636363626363636263636362636363, subkey9=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-030 start re-pulsed at cycle 4 of expansion with different keyword -> ignored; final keys match first keyword, done at cycle 10.
REQ-031 n_rst asserted at cycle 5 of expansion -> busy, done, all subkeys 0 same cycle; after release no activity until start.
REQ-032 Back-to-back: start in DONE with FIPS-197 key after zero-key run -> done drops next cycle, reasserts 10 cycles later with FIPS-197 values.
